// File: rtl/ha_pkg.sv
// Shared types for the half-adder result FIFO: the stored entry layout and
// the width of the saturating event counters.
package ha_pkg;

    localparam int TALLY_W       = 8;
    // Widest tag the entry can carry; narrower tags are zero-extended on store.
    localparam int HA_ADDR_MAX_W = 16;

    typedef struct packed {
        logic [HA_ADDR_MAX_W-1:0] addr;
        logic                     carry;
        logic                     sum;
    } ha_entry_t;

endpackage

// File: rtl/ha_fifo_mem.sv
// Entry storage for ha_result_fifo: DEPTH entries, one synchronous write port,
// one asynchronous read port. Contents are never reset.
module ha_fifo_mem
    import ha_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  ha_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output ha_entry_t        rdata
);

    ha_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ha_result_fifo.sv
// Registered FIFO for half-adder results with sticky overflow flag and a
// saturating carry tally. Optional drop counter under HA_RESULT_FIFO_DROP_CNT_EN.
module ha_result_fifo
    import ha_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sum,
    input  logic                     in_carry,
    input  logic [ADDR_W-1:0]        in_addr,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sum,
    output logic                     out_carry,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [TALLY_W-1:0]       carry_tally
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
    ,
    output logic [TALLY_W-1:0]       drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             refuse;
    ha_entry_t        wr_entry;
    ha_entry_t        rd_entry;
    logic             unused_rd_addr;

    // Handshakes depend only on registered count, so out_ready never reaches in_ready.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign refuse    = in_valid && !in_ready;

    assign wr_entry = '{addr: HA_ADDR_MAX_W'(in_addr), carry: in_carry, sum: in_sum};

    ha_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign out_addr       = rd_entry.addr[ADDR_W-1:0];
    assign out_carry      = rd_entry.carry;
    assign out_sum        = rd_entry.sum;
    assign unused_rd_addr = ^rd_entry.addr;

    // Pointers are PTR_W bits wide, so DEPTH-1 wraps to 0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf         <= 1'b0;
            carry_tally <= '0;
        end else begin
            if (refuse) begin
                ovf <= 1'b1;
            end
            if (push && in_carry) begin
                carry_tally <= sat_inc(carry_tally);
            end
        end
    end

`ifdef HA_RESULT_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (refuse) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`else
    // Refused offers are only recorded by the sticky ovf flag.
`endif

endmodule

// File: tb/tb_ha_result_fifo.sv
// Self-checking bench for ha_result_fifo against a queue-based reference model.
module tb_ha_result_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              carry;
        logic              sum;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sum = 1'b0;
    logic              in_carry = 1'b0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_sum;
    logic              out_carry;
    logic [ADDR_W-1:0] out_addr;
    logic [CW-1:0]     count;
    logic              ovf;
    logic [7:0]        carry_tally;
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    ha_result_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sum      (in_sum),
        .in_carry    (in_carry),
        .in_addr     (in_addr),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carry   (out_carry),
        .out_addr    (out_addr),
        .count       (count),
        .ovf         (ovf),
        .carry_tally (carry_tally)
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain queue plus scalar flags/counters.
    ent_t q[$];
    bit   m_ovf;
    int   m_tally;
    int   m_drop;
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic c,
                         input logic s, input logic r);
        in_valid  = v;
        in_addr   = a;
        in_carry  = c;
        in_sum    = s;
        out_ready = r;
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf   = 1'b0;
        m_tally = 0;
        m_drop  = 0;
    endtask

    // Advance one clock, applying the FIFO rules to the model; returns 1ns after the edge.
    task automatic cycle();
        bit   full, acc, pp, offer;
        ent_t e;
        full   = (q.size() == DEPTH);
        offer  = in_valid;
        acc    = in_valid && !full;
        pp     = out_ready && (q.size() != 0);
        e.addr = in_addr; e.carry = in_carry; e.sum = in_sum;
        @(posedge clk);
        if (offer && full) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        if (pp) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (e.carry && m_tally < 255) m_tally++;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, '0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (carry_tally !== 8'd0) begin errors++; $display("FAIL reset_tally got=%0d exp=0", carry_tally); end
        rst = 1'b0;
    endtask

    task automatic test_basic_push();
        drive(1, 4'd3, 1, 0, 0);
        cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_addr !== 4'd3) begin errors++; $display("FAIL basic_out_addr got=%0d exp=3", out_addr); end
        checks++; if (out_carry !== 1'b1 || out_sum !== 1'b0) begin errors++; $display("FAIL basic_bits got=c%b s%b exp=c1 s0", out_carry, out_sum); end
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL basic_count got=%0d exp=1", count); end
        checks++; if (carry_tally !== 8'd1) begin errors++; $display("FAIL basic_tally got=%0d exp=1", carry_tally); end
        drive(0, '0, 0, 0, 1);
        cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop count=%0d valid=%b exp=0/0", count, out_valid); end
    endtask

    task automatic test_fill_ovf();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, ADDR_W'(i), 1'($urandom), 1'($urandom), 0);
            cycle();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count got=%0d exp=%0d", count, DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", ovf); end
        checks++; if (carry_tally !== 8'(m_tally)) begin errors++; $display("FAIL fill_tally got=%0d exp=%0d", carry_tally, m_tally); end
        drive(1, 4'd9, 1, 1, 0);
        cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", count, DEPTH); end
        checks++; if (carry_tally !== 8'(m_tally)) begin errors++; $display("FAIL ovf_tally got=%0d exp=%0d", carry_tally, m_tally); end
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
    endtask

    task automatic test_drain();
        drive(0, '0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_addr !== ADDR_W'(i)) begin errors++; $display("FAIL drain_order[%0d] got=v%b a%0d exp=v1 a%0d", i, out_valid, out_addr, i); end
            checks++; if (out_carry !== q[0].carry || out_sum !== q[0].sum) begin errors++; $display("FAIL drain_bits[%0d] got=c%b s%b exp=c%b s%b", i, out_carry, out_sum, q[0].carry, q[0].sum); end
            cycle();
        end
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL drain_empty got=v%b n%0d exp=v0 n0", out_valid, count); end
        repeat (3) cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (count !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL underflow got=n%0d r%b exp=n0 r1", count, in_ready); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, ADDR_W'(8 + i), 1'($urandom), 1'($urandom), 0);
            cycle();
        end
        drive(1, 4'd5, 1, 1, 1);
        cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (count !== CW'(q.size()) || count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_pushpop_count got=%0d exp=%0d", count, DEPTH - 1); end
        checks++; if (out_addr !== q[0].addr) begin errors++; $display("FAIL full_pushpop_head got=%0d exp=%0d", out_addr, q[0].addr); end
        checks++; if (carry_tally !== 8'(m_tally)) begin errors++; $display("FAIL full_pushpop_tally got=%0d exp=%0d", carry_tally, m_tally); end
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL full_pushpop_drop got=%0d exp=%0d", drop_cnt, m_drop); end
`endif
        drive(0, '0, 0, 0, 1);
        while (q.size() != 0) cycle();
        drive(0, '0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1, ADDR_W'($urandom), 1'($urandom), 1'($urandom), 0);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, ADDR_W'($urandom), 1'($urandom), 1'($urandom), 1);
            cycle();
            checks++; if (count !== CW'(4)) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=4", i, count); end
            checks++; if (out_addr !== q[0].addr || out_carry !== q[0].carry || out_sum !== q[0].sum) begin
                errors++; $display("FAIL b2b_head[%0d] got=a%0d c%b s%b exp=a%0d c%b s%b", i, out_addr, out_carry, out_sum, q[0].addr, q[0].carry, q[0].sum);
            end
        end
        drive(0, '0, 0, 0, 1);
        while (q.size() != 0) cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (count !== '0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", count); end
    endtask

    task automatic test_carry_sat();
        for (int i = 0; i < 300; i++) begin
            drive(1, ADDR_W'(i), 1, 1'($urandom), 1);
            cycle();
            if (i % 50 == 49) begin
                checks++; if (carry_tally !== 8'(m_tally)) begin errors++; $display("FAIL tally[%0d] got=%0d exp=%0d", i, carry_tally, m_tally); end
            end
        end
        drive(0, '0, 0, 0, 1);
        while (q.size() != 0) cycle();
        drive(0, '0, 0, 0, 0);
        checks++; if (carry_tally !== 8'd255) begin errors++; $display("FAIL tally_sat got=%0d exp=255", carry_tally); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) begin
            drive(1, ADDR_W'($urandom), 1'($urandom), 1'($urandom), 0);
            cycle();
        end
        drive(0, '0, 0, 0, 0);
        checks++; if (count !== CW'(5)) begin errors++; $display("FAIL mid_count_pre got=%0d exp=5", count); end
        #3 rst = 1'b1;
        #1;
        model_clear();
        checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL mid_rst_fifo got=v%b n%0d exp=v0 n0", out_valid, count); end
        checks++; if (ovf !== 1'b0 || carry_tally !== 8'd0) begin errors++; $display("FAIL mid_rst_flags got=o%b t%0d exp=o0 t0", ovf, carry_tally); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_drop got=%0d exp=0", drop_cnt); end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        test_basic_push();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 60), ADDR_W'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70)));
            cycle();
            checks++; if (count !== CW'(q.size()) || in_ready !== (q.size() != DEPTH) || out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_state[%0d] got=n%0d r%b v%b exp=n%0d", i, count, in_ready, out_valid, q.size());
            end
            if (q.size() != 0) begin
                checks++; if (out_addr !== q[0].addr || out_carry !== q[0].carry || out_sum !== q[0].sum) begin
                    errors++; $display("FAIL rand_head[%0d] got=a%0d c%b s%b exp=a%0d c%b s%b", i, out_addr, out_carry, out_sum, q[0].addr, q[0].carry, q[0].sum);
                end
            end
            checks++; if (ovf !== m_ovf || carry_tally !== 8'(m_tally)) begin errors++; $display("FAIL rand_flags[%0d] got=o%b t%0d exp=o%b t%0d", i, ovf, carry_tally, m_ovf, m_tally); end
`ifdef HA_RESULT_FIFO_DROP_CNT_EN
            checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rand_drop[%0d] got=%0d exp=%0d", i, drop_cnt, m_drop); end
`endif
        end
        drive(0, '0, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_push();
        test_fill_ovf();
        test_drain();
        test_full_push_pop();
        test_back_to_back();
        test_carry_sat();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ha_result_fifo.md
HA_RESULT_FIFO -- requirements
Module: ha_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 4, width of the result tag address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  producer presents a half-adder result this cycle.
REQ-006 SHALL have port in_sum  input  1  half-adder sum bit.
REQ-007 SHALL have port in_carry  input  1  half-adder carry bit.
REQ-008 SHALL have port in_addr  input  ADDR_W  tag/address accompanying the result.
REQ-009 SHALL have port in_ready  output  1  FIFO can accept an entry this cycle.
REQ-010 SHALL have port out_valid  output  1  head entry is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL have port out_sum, out_carry  output  1 each  head entry result bits.
REQ-013 SHALL have port out_addr  output  ADDR_W  head entry tag.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port ovf  output  1  sticky flag: an entry was offered while full.
REQ-016 SHALL have port carry_tally  output  8  count of accepted entries with carry=1.

Function
REQ-017 SHALL push {in_addr,in_carry,in_sum} on a clock edge when in_valid && in_ready.
REQ-018 SHALL pop the head entry on a clock edge when out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count != DEPTH), from registered count only; no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (count != 0); out_* hold the head entry while out_valid.
REQ-021 SHALL give push-to-out_valid latency of exactly 1 cycle when empty (no fall-through).
REQ-022 SHALL, on simultaneous push and pop when 0<count<DEPTH, leave count unchanged and preserve order.
REQ-023 SHALL, when full, refuse a push even if a pop occurs in the same cycle; the pop still completes.
REQ-024 SHALL, when empty, ignore out_ready; count never underflows.
REQ-025 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-026 SHALL set ovf on any edge where in_valid && !in_ready; ovf stays 1 until reset.
REQ-027 SHALL increment carry_tally on each accepted push with in_carry=1, saturating at 255.
REQ-028 SHALL keep out_* values don't-care while out_valid=0 (bench must not check them).

Reset
REQ-029 SHALL, on rst assertion at any time (including mid-transfer), immediately clear pointers, count, ovf, carry_tally; out_valid=0, in_ready=1.
REQ-030 SHALL discard all stored entries on reset; storage contents need not be cleared.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-032 SHALL honour macro HA_RESULT_FIFO_DROP_CNT_EN: when defined, add output drop_cnt (8 bits) incrementing, saturating at 255, per refused offer (REQ-026 condition), cleared by reset.
REQ-033 SHALL, without HA_RESULT_FIFO_DROP_CNT_EN, omit the drop_cnt port and logic entirely; all other behaviour identical.

Structure
REQ-034 SHALL place the entry struct type (addr, carry, sum) and the tally width constant in shared package ha_pkg.
REQ-035 SHALL implement storage as one sub-module ha_fifo_mem (DEPTH x entry, one write port, one async read port); control stays in ha_result_fifo.

Verification
REQ-036 Reset then push (a=1,b=1 result: sum=0,carry=1,addr=3) -> next cycle out_valid=1, out_addr=3, out_carry=1, count=1, carry_tally=1.
REQ-037 Push 8 entries addr 0..7 with out_ready=0 -> count=8, in_ready=0; 9th offer -> ovf=1, count stays 8 (drop_cnt=1 if macro set).
REQ-038 From full, drain with out_ready=1 -> out_addr sequence 0..7 in order, then out_valid=0, count=0.
REQ-039 Hold count=4, push and pop same cycle for 20 cycles -> count stays 4, pointers wrap, order preserved.
REQ-040 Assert rst mid-stream with count=5 -> same instant out_valid=0, count=0, ovf=0, carry_tally=0; next push behaves as REQ-036.
REQ-041 Push 300 entries with carry=1 while draining -> carry_tally saturates at 255.
